// File: rtl/ysyx_24100006_wb_arbiter.sv
// ysyx_24100006_wb_arbiter
// Shares the single GPR write port between EXU (src0) and LSU (src1) writebacks.
// The winning request is captured in a one-stage commit register that drives the
// GPR write port. A per-register busy scoreboard answers RAW queries (rs1/rs2)
// and gates issue for WAW hazards.
// Configuration macro: YSYX_24100006_WBARB_RR_EN
//   defined   -> round-robin between the two sources on a tie
//   undefined -> fixed priority, LSU (src1) wins every tie
module ysyx_24100006_wb_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  output logic                     issue_ready,
  input  logic [ADDR_WIDTH-1:0]    rs1,
  input  logic [ADDR_WIDTH-1:0]    rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  input  logic                     src0_valid,
  output logic                     src0_ready,
  input  logic [ADDR_WIDTH-1:0]    src0_rd,
  input  logic [DATA_WIDTH-1:0]    src0_data,
  input  logic                     src1_valid,
  output logic                     src1_ready,
  input  logic [ADDR_WIDTH-1:0]    src1_rd,
  input  logic [DATA_WIDTH-1:0]    src1_data,
  output logic                     gpr_wen,
  output logic [ADDR_WIDTH-1:0]    gpr_waddr,
  output logic [DATA_WIDTH-1:0]    gpr_wdata,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_SRC0 = 2'd1,
    GNT_SRC1 = 2'd2
  } grant_e;

  grant_e                grant;
  logic                  tie_pick_src1;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  commit_en;
  logic                  issue_fire;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

`ifdef YSYX_24100006_WBARB_RR_EN
  // last granted source: 0 = src0, 1 = src1; reset to 1 so src0 wins the first tie
  logic last_q;

  // Track the most recently granted source for round-robin tie breaking
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant == GNT_SRC0) begin
      last_q <= 1'b0;
    end else if (grant == GNT_SRC1) begin
      last_q <= 1'b1;
    end
  end

  assign tie_pick_src1 = ~last_q;
`else
  // Fixed priority: the LSU always wins a tie
  assign tie_pick_src1 = 1'b1;
`endif

  // Pick a winner among the valid sources; ready is purely combinational
  always_comb begin
    // NOTE: default first, so no path through the block leaves grant unassigned (no latch).
    grant = GNT_NONE;
    if (src0_valid && src1_valid) begin
      grant = tie_pick_src1 ? GNT_SRC1 : GNT_SRC0;
    end else if (src0_valid) begin
      grant = GNT_SRC0;
    end else if (src1_valid) begin
      grant = GNT_SRC1;
    end
  end

  assign src0_ready = (grant == GNT_SRC0);
  assign src1_ready = (grant == GNT_SRC1);

  // Route the winner's destination and data toward the commit register
  always_comb begin
    win_rd   = src0_rd;
    win_data = src0_data;
    if (grant == GNT_SRC1) begin
      win_rd   = src1_rd;
      win_data = src1_data;
    end
  end

  // A grant to x0 completes the handshake but never produces a GPR write
  assign commit_en = (grant != GNT_NONE) && (win_rd != '0);

  // Commit stage: drains every cycle; address/data hold when nothing commits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_wen <= commit_en;
      if (commit_en) begin
        gpr_waddr <= win_rd;
        gpr_wdata <= win_data;
      end
    end
  end

  // Issue may proceed when its destination has no write outstanding (x0 never does)
  assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  // Scoreboard next state: clear the register committing this cycle, set the one issuing.
  // The set is applied last so that a stray write to a non-busy rd cannot hide a new issue.
  always_comb begin
    busy_d = busy_q;
    if (gpr_wen) begin
      busy_d[gpr_waddr] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; busy stays visible through the commit cycle itself
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset as a whole.
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = (rs1 != '0) && busy_q[rs1];
  assign rs2_busy = (rs2 != '0) && busy_q[rs2];
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_ysyx_24100006_wb_arbiter.sv
// tb_ysyx_24100006_wb_arbiter
// Directed scenarios followed by randomized traffic. A reference model predicts grants,
// ready, scoreboard state and queues every expected GPR commit; an independent monitor
// pops that queue whenever the DUT asserts gpr_wen.
module tb_ysyx_24100006_wb_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 2**AW;

  logic          clk;
  logic          reset;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          src0_valid;
  logic          src0_ready;
  logic [AW-1:0] src0_rd;
  logic [DW-1:0] src0_data;
  logic          src1_valid;
  logic          src1_ready;
  logic [AW-1:0] src1_rd;
  logic [DW-1:0] src1_data;
  logic          gpr_wen;
  logic [AW-1:0] gpr_waddr;
  logic [DW-1:0] gpr_wdata;
  logic [NR-1:0] busy_vec;

  ysyx_24100006_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .src0_valid (src0_valid),
    .src0_ready (src0_ready),
    .src0_rd    (src0_rd),
    .src0_data  (src0_data),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .src1_rd    (src1_rd),
    .src1_data  (src1_data),
    .gpr_wen    (gpr_wen),
    .gpr_waddr  (gpr_waddr),
    .gpr_wdata  (gpr_wdata),
    .busy_vec   (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance to just after the next rising edge, where inputs are driven
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t           exp_q[$];
  logic [NR-1:0] m_busy    = '0;
  logic          m_pend    = 1'b0;
  logic [AW-1:0] m_pend_rd = '0;
  int            m_last    = 1;
  int            m_gnt;
  logic          m_issue_ok;
  wb_t           m_wb;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_gpr_wen", gpr_wen, 0);
      check("rst_busy_vec", busy_vec, 0);
      m_busy = '0;
      m_pend = 1'b0;
      m_last = 1;
      exp_q.delete();
    end else begin
      if (src0_valid && src1_valid) begin
`ifdef YSYX_24100006_WBARB_RR_EN
        m_gnt = (m_last == 0) ? 1 : 0;
`else
        m_gnt = 1;
`endif
      end else if (src0_valid) m_gnt = 0;
      else if (src1_valid)     m_gnt = 1;
      else                     m_gnt = -1;

      m_issue_ok = (issue_rd == 0) || !m_busy[issue_rd];
      check("m_src0_ready", src0_ready, (m_gnt == 0));
      check("m_src1_ready", src1_ready, (m_gnt == 1));
      check("m_rs1_busy", rs1_busy, (rs1 != 0) && m_busy[rs1]);
      check("m_rs2_busy", rs2_busy, (rs2 != 0) && m_busy[rs2]);
      check("m_issue_ready", issue_ready, m_issue_ok);
      check("m_busy_vec", busy_vec, m_busy);

      // state after the coming edge
      if (m_pend) m_busy[m_pend_rd] = 1'b0;
      if (issue_valid && m_issue_ok && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_pend = 1'b0;
      if (m_gnt >= 0) begin
        m_last    = m_gnt;
        m_wb.rd   = (m_gnt == 0) ? src0_rd : src1_rd;
        m_wb.data = (m_gnt == 0) ? src0_data : src1_data;
        if (m_wb.rd != 0) begin
          exp_q.push_back(m_wb);
          m_pend    = 1'b1;
          m_pend_rd = m_wb.rd;
        end
      end
    end
  end

  // ---------------- commit monitor ----------------
  wb_t mon_wb;
  always @(negedge clk) begin
    if (!reset && gpr_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_commit", gpr_wen, 0);
      end else begin
        mon_wb = exp_q.pop_front();
        check("mon_gpr_waddr", gpr_waddr, mon_wb.rd);
        check("mon_gpr_wdata", gpr_wdata, mon_wb.data);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic g0, g1;
  logic exp_src1;

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    src0_valid = 0; src0_rd = 0; src0_data = 0;
    src1_valid = 0; src1_rd = 0; src1_data = 0;
    repeat (2) step();
    reset = 1'b0;

    // 1: single EXU writeback, one-cycle latency, then idle
    src0_valid = 1; src0_rd = 5; src0_data = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_src0_ready", src0_ready, 1);
    check("t1_src1_ready", src1_ready, 0);
    step(); src0_valid = 0;
    @(negedge clk);
    check("t1_gpr_wen", gpr_wen, 1);
    check("t1_gpr_waddr", gpr_waddr, 5);
    check("t1_gpr_wdata", gpr_wdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    check("t1_gpr_wen_off", gpr_wen, 0);

    // 2: scoreboard set by issue, cleared the cycle after the commit cycle
    step(); issue_valid = 1; issue_rd = 3;
    @(negedge clk);
    check("t2_issue_ready_free", issue_ready, 1);
    step(); issue_valid = 0; rs1 = 3;
    @(negedge clk);
    check("t2_rs1_busy_set", rs1_busy, 1);
    check("t2_issue_ready_busy", issue_ready, 0);
    step(); src1_valid = 1; src1_rd = 3; src1_data = 32'hCAFE0003;
    @(negedge clk);
    check("t2_src1_ready", src1_ready, 1);
    step(); src1_valid = 0;
    @(negedge clk);
    check("t2_commit_wen", gpr_wen, 1);
    check("t2_commit_waddr", gpr_waddr, 3);
    check("t2_rs1_busy_commit", rs1_busy, 1);
    step();
    @(negedge clk);
    check("t2_rs1_busy_clear", rs1_busy, 0);

    // 3: both sources valid for four cycles, from a fresh reset
    step(); rs1 = 0; reset = 1;
    step(); reset = 0;
    src0_valid = 1; src0_rd = 1; src0_data = 32'h0000_0011;
    src1_valid = 1; src1_rd = 2; src1_data = 32'h0000_0022;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef YSYX_24100006_WBARB_RR_EN
      exp_src1 = (i % 2 == 1);
`else
      exp_src1 = 1'b1;
`endif
      check($sformatf("t3_src0_ready_%0d", i), src0_ready, !exp_src1);
      check($sformatf("t3_src1_ready_%0d", i), src1_ready, exp_src1);
      step();
    end
    src0_valid = 0; src1_valid = 0;

    // 4: writeback to x0 completes but never writes
    src0_valid = 1; src0_rd = 0; src0_data = 32'h0000_1234;
    @(negedge clk);
    check("t4_src0_ready", src0_ready, 1);
    step(); src0_valid = 0;
    @(negedge clk);
    check("t4_gpr_wen", gpr_wen, 0);
    check("t4_busy_vec", busy_vec, 0);

    // 5: reset during the commit cycle of rd=7
    step(); issue_valid = 1; issue_rd = 7;
    step(); issue_valid = 0;
    src0_valid = 1; src0_rd = 7; src0_data = 32'h7777_0007;
    @(negedge clk);
    check("t5_src0_ready", src0_ready, 1);
    check("t5_busy7", busy_vec[7], 1);
    step(); src0_valid = 0; reset = 1;
    #1;
    check("t5_rst_gpr_wen", gpr_wen, 0);
    check("t5_rst_busy_vec", busy_vec, 0);
    step(); reset = 0; rs1 = 7;
    @(negedge clk);
    check("t5_rs1_busy", rs1_busy, 0);

    // 6: issue rd=4 in the same cycle rd=6 commits
    step(); rs1 = 0; issue_valid = 1; issue_rd = 6;
    step(); issue_valid = 0;
    src0_valid = 1; src0_rd = 6; src0_data = 32'h6666_0006;
    step(); src0_valid = 0; issue_valid = 1; issue_rd = 4;
    @(negedge clk);
    check("t6_commit_wen", gpr_wen, 1);
    check("t6_commit_waddr", gpr_waddr, 6);
    step(); issue_valid = 0;
    @(negedge clk);
    check("t6_busy4", busy_vec[4], 1);
    check("t6_busy6", busy_vec[6], 0);
    step(); src0_valid = 1; src0_rd = 4; src0_data = 32'h4444_0004;
    step(); src0_valid = 0;
    step();

    // randomized traffic; sources hold their request until granted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = src0_valid && src0_ready;
      g1 = src1_valid && src1_ready;
      step();
      reset = 1'b0;
      if (!src0_valid || g0) begin
        src0_valid = ($urandom_range(0, 3) != 0);
        src0_rd    = 4'($urandom);
        src0_data  = $urandom;
      end
      if (!src1_valid || g1) begin
        src1_valid = ($urandom_range(0, 2) != 0);
        src1_rd    = 4'($urandom);
        src1_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd    = 4'($urandom);
      rs1         = 4'($urandom);
      rs2         = 4'($urandom);
      if (c % 1000 == 999) begin
        reset = 1'b1;
        src0_valid = 0; src1_valid = 0; issue_valid = 0;
      end
    end

    // drain and confirm every expected commit appeared
    step();
    reset = 0; src0_valid = 0; src1_valid = 0; issue_valid = 0;
    repeat (3) step();
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
